// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths, RV32I load/store width codes and LSU state encodings.
package lsu_pkg;

    localparam int CPU_WIDTH = 32;

    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;
    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR  = 3'd4
    } lsu_state_e;

    function automatic logic [CPU_WIDTH-1:0] word_align(input logic [CPU_WIDTH-1:0] addr);
        return {addr[CPU_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: execute-side request/response and data-memory bus signals of the LSU.
interface lsu_if;
    import lsu_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [2:0]           req_funct3;
    logic [CPU_WIDTH-1:0] req_addr;
    logic [CPU_WIDTH-1:0] req_wdata;
    logic [4:0]           req_rd;
    logic                 busy;
    logic                 rsp_valid;
    logic [CPU_WIDTH-1:0] rsp_rdata;
    logic [4:0]           rsp_rd;
    logic                 misalign_err;
    logic                 bus_err;
    logic                 mem_req;
    logic                 mem_gnt;
    logic                 mem_we;
    logic [CPU_WIDTH-1:0] mem_addr;
    logic [3:0]           mem_be;
    logic [CPU_WIDTH-1:0] mem_wdata;
    logic                 mem_rvalid;
    logic [CPU_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, busy, rsp_valid, rsp_rdata, rsp_rd, misalign_err, bus_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, busy, rsp_valid, rsp_rdata, rsp_rd, misalign_err, bus_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores, load extraction/extension and
// alignment/legality check. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic                 we,
    input  logic [2:0]           funct3,
    input  logic [1:0]           addr_lo,
    input  logic [CPU_WIDTH-1:0] wdata,
    input  logic [CPU_WIDTH-1:0] rdata,
    output logic [3:0]           be,
    output logic [CPU_WIDTH-1:0] wdata_lane,
    output logic [CPU_WIDTH-1:0] rdata_ext,
    output logic                 err
);

    logic [CPU_WIDTH-1:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        err        = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                if (we) begin
                    be         = 4'b0001 << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end
            end
            2'b01: begin
                if (we) begin
                    be         = 4'b0011 << addr_lo;
                    wdata_lane = {2{wdata[15:0]}};
                end
                err = addr_lo[0];
            end
            2'b10:   err = (addr_lo != 2'b00);
            default: err = 1'b1;
        endcase
        // unsigned variants exist only for byte/half loads
        if (funct3[2] && (we || funct3[1]))
            err = 1'b1;
    end

    always_comb begin
        case (funct3)
            LSU_LB:  rdata_ext = {{(CPU_WIDTH-8){shifted[7]}}, shifted[7:0]};
            LSU_LH:  rdata_ext = {{(CPU_WIDTH-16){shifted[15]}}, shifted[15:0]};
            LSU_LBU: rdata_ext = {{(CPU_WIDTH-8){1'b0}}, shifted[7:0]};
            LSU_LHU: rdata_ext = {{(CPU_WIDTH-16){1'b0}}, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit behind the ALU; one data-memory transaction per accepted request.
// Define LSU_TIMEOUT_EN to add a REQ/WAIT watchdog (TIMEOUT_CYCLES) that raises bus_err.
//   state | meaning
//   IDLE  | ready, req_ready high
//   REQ   | mem_req held with stable address/lanes until mem_gnt
//   WAIT  | load granted, waiting for mem_rvalid
//   RESP  | rsp_valid pulse
//   ERR   | misalign_err pulse
module lsu
    import lsu_pkg::*;
`ifdef LSU_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 256
)
`endif
(
    input  logic clk,
    input  logic rst,
    lsu_if.slave bus
);

    lsu_state_e state_q, state_d;

    logic                 we_q;
    logic [2:0]           funct3_q;
    logic [1:0]           addr_lo_q;
    logic [4:0]           rd_q;
    logic [CPU_WIDTH-1:0] mem_addr_q;
    logic [3:0]           mem_be_q;
    logic [CPU_WIDTH-1:0] mem_wdata_q;
    logic [CPU_WIDTH-1:0] rsp_rdata_q;
    logic [4:0]           rsp_rd_q;

    logic                 idle;
    logic                 accept;
    logic                 tmo_hit;
    logic                 al_we;
    logic [2:0]           al_funct3;
    logic [1:0]           al_addr_lo;
    logic [3:0]           al_be;
    logic [CPU_WIDTH-1:0] al_wdata;
    logic [CPU_WIDTH-1:0] al_rdata;
    logic                 al_err;

    assign idle   = (state_q == ST_IDLE);
    assign accept = bus.req_valid & idle;

    // Acceptance (IDLE) and load extraction (WAIT) never overlap, so one aligner serves both.
    assign al_we      = idle ? bus.req_we         : we_q;
    assign al_funct3  = idle ? bus.req_funct3     : funct3_q;
    assign al_addr_lo = idle ? bus.req_addr[1:0]  : addr_lo_q;

    lsu_align u_align (
        .we         (al_we),
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .wdata      (bus.req_wdata),
        .rdata      (bus.mem_rdata),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata),
        .err        (al_err)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept)
                    state_d = al_err ? ST_ERR : ST_REQ;
            end
            ST_REQ: begin
                if (bus.mem_gnt)
                    state_d = we_q ? ST_IDLE : ST_WAIT;
                else if (tmo_hit)
                    state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (bus.mem_rvalid)
                    state_d = ST_RESP;
                else if (tmo_hit)
                    state_d = ST_IDLE;
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            rd_q        <= 5'd0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_rd_q    <= 5'd0;
        end else begin
            if (accept && !al_err) begin
                we_q        <= bus.req_we;
                funct3_q    <= bus.req_funct3;
                addr_lo_q   <= bus.req_addr[1:0];
                rd_q        <= bus.req_rd;
                mem_addr_q  <= word_align(bus.req_addr);
                mem_be_q    <= al_be;
                mem_wdata_q <= al_wdata;
            end
            if (state_q == ST_WAIT && bus.mem_rvalid) begin
                rsp_rdata_q <= al_rdata;
                rsp_rd_q    <= rd_q;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             bus_err_q;

    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // REQ is only entered from IDLE, so holding the count at zero in IDLE clears it on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                tmo_cnt_q <= '0;
            end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
                if (tmo_hit && ((state_q == ST_REQ && !bus.mem_gnt) ||
                                (state_q == ST_WAIT && !bus.mem_rvalid)))
                    bus_err_q <= 1'b1;
            end
        end
    end

    assign bus.bus_err = bus_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    assign bus.req_ready    = idle;
    assign bus.busy         = !idle;
    assign bus.rsp_valid    = (state_q == ST_RESP);
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.rsp_rd       = rsp_rd_q;
    assign bus.misalign_err = (state_q == ST_ERR);
    assign bus.mem_req      = (state_q == ST_REQ);
    assign bus.mem_we       = we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_be       = mem_be_q;
    assign bus.mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed vectors with a scoreboard; stimulus pushes expected bus/response
// events, a monitor pops and compares them as the LSU presents them.
module tb_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lsu_if bus();

`ifdef LSU_TIMEOUT_EN
    lsu #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    lsu dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } bus_exp_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  rd;
    } rsp_exp_t;

    bus_exp_t exp_bus[$];
    rsp_exp_t exp_rsp[$];
    int exp_mis  = 0;
    int exp_berr = 0;
    int n_cmp    = 0;
    int n_bad    = 0;

    int          gnt_delay_cfg = 0;
    int          rv_delay_cfg  = 1;
    int          gnt_wait      = 0;
    int          rv_wait       = 0;
    bit          rv_pending    = 1'b0;
    bit          hold_gnt      = 1'b0;
    logic [31:0] rd_val        = 32'h0;

    function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void chk1(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endfunction

    // memory model: grant after gnt_delay_cfg cycles of mem_req, rvalid rv_delay_cfg after grant
    initial begin
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (rv_pending) begin
                if (rv_wait == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rd_val;
                    rv_pending     = 1'b0;
                end else begin
                    rv_wait--;
                end
            end
            if (bus.mem_req && !hold_gnt) begin
                if (gnt_wait == 0) begin
                    bus.mem_gnt = 1'b1;
                    if (!bus.mem_we) begin
                        rv_pending = 1'b1;
                        rv_wait    = rv_delay_cfg - 1;
                    end
                end else begin
                    gnt_wait--;
                end
            end else begin
                gnt_wait = gnt_delay_cfg;
            end
        end
    end

    initial begin
        bus_exp_t eb;
        rsp_exp_t er;
        forever begin
            @(negedge clk);
            #2;
            if (bus.mem_req) begin
                if (exp_bus.size() == 0) begin
                    chk1("unexpected_mem_req", bus.mem_req, 1'b0);
                end else begin
                    eb = exp_bus[0];
                    chk32("mem_addr", bus.mem_addr, eb.addr);
                    chk32("mem_be", {28'h0, bus.mem_be}, {28'h0, eb.be});
                    chk1("mem_we", bus.mem_we, eb.we);
                    if (eb.we)
                        chk32("mem_wdata", bus.mem_wdata, eb.wdata);
                    if (bus.mem_gnt)
                        void'(exp_bus.pop_front());
                end
            end
            if (bus.rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    chk1("unexpected_rsp_valid", bus.rsp_valid, 1'b0);
                end else begin
                    er = exp_rsp.pop_front();
                    chk32("rsp_rdata", bus.rsp_rdata, er.rdata);
                    chk32("rsp_rd", {27'h0, bus.rsp_rd}, {27'h0, er.rd});
                end
            end
            if (bus.misalign_err) begin
                if (exp_mis == 0) begin
                    chk1("unexpected_misalign_err", bus.misalign_err, 1'b0);
                end else begin
                    exp_mis--;
                    chk1("mem_req_during_err", bus.mem_req, 1'b0);
                end
            end
            if (bus.bus_err) begin
                if (exp_berr == 0) begin
                    chk1("unexpected_bus_err", bus.bus_err, 1'b0);
                end else begin
                    exp_berr--;
                    chk1("mem_req_after_bus_err", bus.mem_req, 1'b0);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64)
            chk1("wait_idle_budget", bus.req_ready, 1'b1);
    endtask

    // returns at the first negedge after the accepting clock edge
    task automatic start_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd);
        wait_idle();
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
        @(negedge clk);
        bus.req_valid  = 1'b0;
    endtask

    task automatic bad_op(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        exp_mis++;
        start_op(we, f3, addr, 32'h0, 5'd1);
        #1;
        chk1("err_misalign_pulse", bus.misalign_err, 1'b1);
        chk1("err_req_ready_low", bus.req_ready, 1'b0);
        @(negedge clk);
        #1;
        chk1("err_misalign_one_cycle", bus.misalign_err, 1'b0);
        chk1("err_req_ready_back", bus.req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_rd     = 5'd0;
        #2 rst = 1'b1;
        #10;
        chk1("rst_req_ready", bus.req_ready, 1'b1);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk1("rst_mem_we", bus.mem_we, 1'b0);
        chk32("rst_mem_addr", bus.mem_addr, 32'h0);
        chk32("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
        chk32("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk32("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk32("rst_rsp_rd", {27'h0, bus.rsp_rd}, 32'h0);
        chk1("rst_misalign_err", bus.misalign_err, 1'b0);
        chk1("rst_bus_err", bus.bus_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // SB to the top byte lane, zero-wait grant
        exp_bus.push_back('{32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 1'b1});
        start_op(1'b1, LSU_SB, 32'h0000_1003, 32'h0000_00A5, 5'd0);
        #1;
        chk1("sb_busy_t1", bus.busy, 1'b1);
        chk1("sb_mem_req_t1", bus.mem_req, 1'b1);
        @(negedge clk);
        #1;
        chk1("sb_busy_t2", bus.busy, 1'b0);
        chk1("sb_no_rsp_valid", bus.rsp_valid, 1'b0);

        // LB with latency checks, then LBU on the same word
        rd_val = 32'h12F4_5678;
        exp_bus.push_back('{32'h0000_2000, 4'b1111, 32'h0, 1'b0});
        exp_rsp.push_back('{32'hFFFF_FFF4, 5'd7});
        start_op(1'b0, LSU_LB, 32'h0000_2002, 32'h0, 5'd7);
        #1;
        chk1("lb_mem_req_t1", bus.mem_req, 1'b1);
        @(negedge clk);
        #1;
        chk1("lb_rsp_valid_t2", bus.rsp_valid, 1'b0);
        @(negedge clk);
        #1;
        chk1("lb_rsp_valid_t3", bus.rsp_valid, 1'b1);
        @(negedge clk);
        #1;
        chk1("lb_rsp_valid_t4", bus.rsp_valid, 1'b0);

        exp_bus.push_back('{32'h0000_2000, 4'b1111, 32'h0, 1'b0});
        exp_rsp.push_back('{32'h0000_00F4, 5'd8});
        start_op(1'b0, LSU_LBU, 32'h0000_2002, 32'h0, 5'd8);

        rd_val = 32'h12F4_8765;
        exp_bus.push_back('{32'h0000_2000, 4'b1111, 32'h0, 1'b0});
        exp_rsp.push_back('{32'hFFFF_8765, 5'd10});
        start_op(1'b0, LSU_LH, 32'h0000_2000, 32'h0, 5'd10);

        exp_bus.push_back('{32'h0000_2000, 4'b1111, 32'h0, 1'b0});
        exp_rsp.push_back('{32'h0000_12F4, 5'd11});
        start_op(1'b0, LSU_LHU, 32'h0000_2002, 32'h0, 5'd11);

        exp_bus.push_back('{32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1'b1});
        start_op(1'b1, LSU_SH, 32'h0000_2002, 32'h1234_BEEF, 5'd0);

        exp_bus.push_back('{32'h0000_3004, 4'b1111, 32'h1122_3344, 1'b1});
        start_op(1'b1, LSU_SW, 32'h0000_3004, 32'h1122_3344, 5'd0);
        wait_idle();
        #1;
        chk32("rsp_rdata_held", bus.rsp_rdata, 32'h0000_12F4);
        chk32("rsp_rd_held", {27'h0, bus.rsp_rd}, 32'd11);

        // misaligned and illegal ops
        bad_op(1'b0, LSU_LH, 32'h0000_2001);
        bad_op(1'b0, LSU_LW, 32'h0000_2002);
        bad_op(1'b1, 3'b100, 32'h0000_2000);
        bad_op(1'b0, 3'b011, 32'h0000_2000);

        // LW with grant delayed 3 cycles, rvalid 2 cycles after grant
        gnt_delay_cfg = 3;
        rv_delay_cfg  = 2;
        rd_val        = 32'hDEAD_BEEF;
        exp_bus.push_back('{32'h0000_3000, 4'b1111, 32'h0, 1'b0});
        exp_rsp.push_back('{32'hDEAD_BEEF, 5'd3});
        start_op(1'b0, LSU_LW, 32'h0000_3000, 32'h0, 5'd3);
        wait_idle();
        gnt_delay_cfg = 0;
        rv_delay_cfg  = 1;

`ifdef LSU_TIMEOUT_EN
        hold_gnt = 1'b1;
        exp_bus.push_back('{32'h0000_6000, 4'b1111, 32'h0, 1'b0});
        exp_berr++;
        start_op(1'b0, LSU_LW, 32'h0000_6000, 32'h0, 5'd13);
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk1("tmo_no_early_bus_err", bus.bus_err, 1'b0);
            chk1("tmo_mem_req_held", bus.mem_req, 1'b1);
            @(negedge clk);
        end
        #1;
        chk1("tmo_bus_err_pulse", bus.bus_err, 1'b1);
        chk1("tmo_mem_req_dropped", bus.mem_req, 1'b0);
        chk1("tmo_idle", bus.req_ready, 1'b1);
        void'(exp_bus.pop_front());
        hold_gnt = 1'b0;
`endif

        // reset while WAITing for a load; the late rvalid must be ignored
        rv_delay_cfg = 3;
        rd_val       = 32'hCAFE_F00D;
        exp_bus.push_back('{32'h0000_5000, 4'b1111, 32'h0, 1'b0});
        start_op(1'b0, LSU_LW, 32'h0000_5000, 32'h0, 5'd9);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk1("rst_wait_busy", bus.busy, 1'b0);
        chk1("rst_wait_mem_req", bus.mem_req, 1'b0);
        chk1("rst_wait_req_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk32("rst_wait_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk32("rst_wait_rsp_rd", {27'h0, bus.rsp_rd}, 32'h0);
        chk1("rst_wait_still_idle", bus.busy, 1'b0);
        rv_delay_cfg = 1;

        // reset while REQ is stalled waiting for grant
        hold_gnt = 1'b1;
        exp_bus.push_back('{32'h0000_4000, 4'b1111, 32'h0, 1'b0});
        start_op(1'b0, LSU_LW, 32'h0000_4000, 32'h0, 5'd4);
        #3 rst = 1'b1;
        #1;
        chk1("rst_req_mem_req", bus.mem_req, 1'b0);
        chk1("rst_req_busy", bus.busy, 1'b0);
        void'(exp_bus.pop_front());
        @(negedge clk);
        rst = 1'b0;
        hold_gnt = 1'b0;

        repeat (6) @(negedge clk);
        #1;
        chk32("left_exp_bus", 32'(exp_bus.size()), 32'h0);
        chk32("left_exp_rsp", 32'(exp_rsp.size()), 32'h0);
        chk32("left_exp_misalign", 32'(exp_mis), 32'h0);
        chk32("left_exp_bus_err", 32'(exp_berr), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
